// File: rtl/aes_pkg.sv
// Shared AES constants and CBC sequencer state encoding.
// Imported by the CBC sequencer and anything that talks to the core.
package aes_pkg;

    localparam int BLK_W = 128;
    localparam int KEY_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KINIT,
        ST_KWAIT,
        ST_ACCEPT,
        ST_CALC,
        ST_CWAIT,
        ST_OUT
    } cbc_state_t;

endpackage

// File: rtl/aes_cbc_seq.sv
// CBC chaining sequencer sitting beside an AES core.
// Handles key setup, per-block chaining and in/out handshakes.
module aes_cbc_seq
    import aes_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             encdec,
    input  logic             keylen,
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             core_init,
    output logic             core_next,
    output logic             core_encdec,
    output logic             core_keylen,
    output logic [KEY_W-1:0] core_key,
    output logic [BLK_W-1:0] core_block,
    input  logic             core_ready,
    input  logic             core_result_valid,
    input  logic [BLK_W-1:0] core_result,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    cbc_state_t state, state_n;

    logic [KEY_W-1:0] key_q;
    logic             keylen_q;
    logic             encdec_q;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] din;

    logic ld_op;
    logic ld_din;
    logic ld_res;
    logic out_clr;

    assign core_key    = key_q;
    assign core_keylen = keylen_q;
    assign core_encdec = encdec_q;
    assign core_block  = encdec_q ? (din ^ chain) : din;
    assign in_ready    = (state == ST_ACCEPT);
    assign busy        = (state != ST_IDLE) && (state != ST_ACCEPT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, core pulses and datapath load strobes.
    always_comb begin
        state_n   = state;
        core_init = 1'b0;
        core_next = 1'b0;
        ld_op     = 1'b0;
        ld_din    = 1'b0;
        ld_res    = 1'b0;
        out_clr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    ld_op   = 1'b1;
                    state_n = ST_KINIT;
                end
            end
            ST_KINIT: begin
                if (core_ready) begin
                    core_init = 1'b1;
                    state_n   = ST_KWAIT;
                end
            end
            ST_KWAIT: begin
                if (core_ready) begin
                    state_n = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (start) begin
                    ld_op   = 1'b1;
                    state_n = ST_KINIT;
                end else if (in_valid) begin
                    ld_din  = 1'b1;
                    state_n = ST_CALC;
                end
            end
            ST_CALC: begin
                if (core_ready) begin
                    core_next = 1'b1;
                    state_n   = ST_CWAIT;
                end
            end
            ST_CWAIT: begin
                if (core_ready && core_result_valid) begin
                    ld_res  = 1'b1;
                    state_n = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_clr = 1'b1;
                    state_n = ST_ACCEPT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand latches, chaining value, result register and block count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q     <= '0;
            keylen_q  <= 1'b0;
            encdec_q  <= 1'b0;
            chain     <= '0;
            din       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            if (ld_op) begin
                key_q    <= key;
                keylen_q <= keylen;
                encdec_q <= encdec;
                chain    <= iv;
                blk_cnt  <= '0;
            end
            if (ld_din) begin
                din <= in_data;
            end
            if (ld_res) begin
                out_data  <= encdec_q ? core_result : (core_result ^ chain);
                chain     <= encdec_q ? core_result : din;
                blk_cnt   <= blk_cnt + CNT_W'(1);
                out_valid <= 1'b1;
            end
            if (out_clr) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/aes_cbc_seq.md
AES_CBC_SEQ -- requirements
Module: aes_cbc_seq

Interface
REQ-001 Parameter CNT_W, default 32, SHALL set the width of the completed-block counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; loads the key and IV, then runs key expansion.
REQ-005 encdec, keylen  input  1 each  1=encrypt/0=decrypt; 1=AES-256/0=AES-128; sampled on start.
REQ-006 key  input  256  cipher key, sampled on start.
REQ-007 iv  input  128  initial chaining value, sampled on start.
REQ-008 in_valid, in_ready  input/output  1 each  input-block handshake.
REQ-009 in_data  input  128  plaintext (encrypt) or ciphertext (decrypt).
REQ-010 out_valid, out_ready  output/input  1 each  output-block handshake.
REQ-011 out_data  output  128  result block.
REQ-012 core_init, core_next  output  1 each  single-cycle pulses to the AES core.
REQ-013 core_encdec, core_keylen, core_key, core_block  output  1/1/256/128  held core operands.
REQ-014 core_ready, core_result_valid, core_result  input  1/1/128  core status and result.
REQ-015 busy  output  1  high in every state except IDLE and ACCEPT.
REQ-016 blk_cnt  output  CNT_W  number of blocks completed since the last start.

Function
REQ-017 The FSM SHALL have the states IDLE, KINIT, KWAIT, ACCEPT, CALC, CWAIT and OUT.
REQ-018 IDLE: start SHALL latch key, keylen, encdec and iv (chain := iv), clear blk_cnt, and go to KINIT.
REQ-019 KINIT: when core_ready=1, the block SHALL pulse core_init for exactly one cycle and go to KWAIT.
REQ-020 KWAIT: core_ready=1 SHALL go to ACCEPT (core_ready is already 0 in the first KWAIT cycle).
REQ-021 ACCEPT: in_ready SHALL be 1; in_valid&in_ready SHALL latch in_data into din and go to CALC.
REQ-022 In the states other than ACCEPT, in_ready SHALL be 0.
REQ-023 CALC: core_block SHALL be din XOR chain when encrypting and din when decrypting; core_next SHALL pulse for one cycle; next state CWAIT.
REQ-024 CWAIT: core_ready&core_result_valid SHALL register out_data.
  - encrypt: out_data := core_result.
  - decrypt: out_data := core_result XOR chain.
  - Same edge: chain := core_result (encrypt) or din (decrypt); blk_cnt increments, wrapping at 2^CNT_W; out_valid := 1; next state OUT.
REQ-025 OUT: out_valid&out_ready SHALL clear out_valid and go to ACCEPT; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 Latency SHALL be: input handshake at edge T, core_next high in cycle T+1, out_valid high one cycle after core_result_valid is sampled.
REQ-027 start in ACCEPT SHALL re-key: it latches new operands, clears blk_cnt, and goes to KINIT.
REQ-028 start in any other state SHALL be ignored.
REQ-029 in_valid SHALL be ignored in IDLE, KINIT and KWAIT.
REQ-030 core_init and core_next SHALL never both be 1, and neither SHALL assert while core_ready=0.
REQ-031 A stale core_result_valid=1 outside CWAIT SHALL have no effect.

Reset
REQ-032 On reset the block SHALL be in IDLE with in_ready=0, out_valid=0, core_init=0, core_next=0, busy=0, blk_cnt=0, out_data=0, chain=0, din=0, and latched key/operands=0.
REQ-033 Reset asserted mid-operation SHALL abort immediately to the reset values; a pending output SHALL be discarded.

Structure
REQ-034 The FSM state encoding and the AES block/key width constants SHALL live in the shared package aes_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the AES core SHALL be instantiated beside it, not inside it.

Verification
REQ-036 AES-128 CBC encrypt: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f.
  - in 6bc1bee22e409f96e93d7e117393172a -> out 7649abac8119b246cee98e9b12e9197d.
  - then in ae2d8a571e03ac9c9eb76fac45af8e51 -> out 5086cb9b507219ee95db113a917678b2; blk_cnt=2.
REQ-037 Decrypt of those two ciphertexts with the same key and iv -> the two plaintexts in order.
REQ-038 Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_data stable, in_ready=0, and no core_next pulse throughout.
REQ-039 Re-key in ACCEPT with a new iv -> blk_cnt=0 and the first block is chained with the new iv.
  - start in CWAIT is ignored and that result is still delivered.
REQ-040 Reset asserted in CWAIT -> all outputs at reset values next cycle.
  - After start, the 36b vector still produces 7649abac8119b246cee98e9b12e9197d.
